// File: rtl/vid_copper_pkg.sv
// Shared definitions for the copper display-list sequencer: opcodes,
// sequencer states and CSR bit layout.
package vid_copper_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_WAIT  = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_DECODE,
    ST_WRITE,
    ST_WAIT,
    ST_END
  } state_t;

  localparam int CSR_ENABLE = 0;
  localparam int CSR_BUSY   = 1;
  localparam int CSR_PC_LSB = 16;

endpackage

// File: rtl/vid_copper_ram.sv
// Command list storage: CPU-side write port, sequencer-side registered read.
module vid_copper_ram #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/vid_copper.sv
// Per-frame display-list sequencer: walks the command list after each
// end-of-frame and issues timed register writes to the video block.
module vid_copper
  import vid_copper_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW:0]   cs_addr,
  input  logic [31:0]   cs_wdata,
  output logic [31:0]   cs_rdata,
  input  logic          cs_we,
  input  logic          cs_cyc,
  output logic          cs_ack,
  output logic [13:0]   m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_wmsk,
  output logic          m_we,
  output logic          m_cyc,
  input  logic          m_ack,
  input  logic [11:0]   tg_y,
  input  logic          tg_eof,
  output logic          busy
);

  localparam logic [AW:0] PC_STEP = {{(AW-1){1'b0}}, 2'b10};

  state_t        state;
  logic [AW-1:0] pc;
  logic          enable;
  logic          last;
  logic          restart_pend;
  logic          rd_pend;
  logic [1:0]    op_q;
  logic [11:0]   line_q;
  logic [13:0]   addr_q;
  logic [31:0]   ram_rdata;
  logic [AW-1:0] ram_raddr;
  logic [AW:0]   pc_sum;
  logic [31:0]   csr_val;
  logic          sl_start;
  logic          sl_wr;
  logic          csr_sel;
  logic          ram_we;
  logic          enable_nx;

  // A CPU write to the CSR in the same cycle as tg_eof must win, so the
  // sequencer always looks at the next enable value rather than the register.
  assign sl_start  = cs_cyc & ~cs_ack & ~rd_pend;
  assign sl_wr     = sl_start & cs_we;
  assign csr_sel   = cs_addr[AW];
  assign ram_we    = sl_wr & ~csr_sel;
  assign enable_nx = (sl_wr & csr_sel) ? cs_wdata[CSR_ENABLE] : enable;

  assign busy      = (state != ST_IDLE);
  assign m_we      = m_cyc;
  assign m_wmsk    = 4'b0000;
  assign ram_raddr = (state == ST_FETCH1) ? {pc[AW-1:1], 1'b1} : pc;
  assign pc_sum    = {1'b0, pc} + PC_STEP;

  vid_copper_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cs_addr[AW-1:0]),
    .wdata (cs_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    csr_val                     = '0;
    csr_val[CSR_ENABLE]         = enable;
    csr_val[CSR_BUSY]           = busy;
    csr_val[CSR_PC_LSB +: AW]   = pc;
  end

  // The list RAM has no CPU read path; reads of it return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable   <= 1'b0;
      cs_ack   <= 1'b0;
      rd_pend  <= 1'b0;
      cs_rdata <= '0;
    end else begin
      enable   <= enable_nx;
      cs_ack   <= 1'b0;
      cs_rdata <= '0;
      if (rd_pend) begin
        rd_pend  <= 1'b0;
        cs_ack   <= 1'b1;
        cs_rdata <= csr_sel ? csr_val : '0;
      end else if (sl_start) begin
        if (cs_we) cs_ack <= 1'b1;
        else       rd_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      pc           <= '0;
      last         <= 1'b0;
      restart_pend <= 1'b0;
      op_q         <= OP_WRITE;
      line_q       <= '0;
      addr_q       <= '0;
      m_cyc        <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_END: begin
          restart_pend <= 1'b0;
          if (tg_eof && enable_nx) begin
            state <= ST_FETCH0;
            pc    <= '0;
            last  <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FETCH0, ST_FETCH1, ST_DECODE, ST_WAIT: begin
          if (!enable_nx) begin
            state <= ST_IDLE;
          end else if (tg_eof) begin
            state <= ST_FETCH0;
            pc    <= '0;
            last  <= 1'b0;
          end else begin
            case (state)
              ST_FETCH0: state <= ST_FETCH1;
              ST_FETCH1: begin
                op_q   <= ram_rdata[31:30];
                line_q <= ram_rdata[27:16];
                addr_q <= ram_rdata[13:0];
                state  <= ST_DECODE;
              end
              // A carry out of pc means the list has been fully walked.
              ST_DECODE: begin
                pc   <= pc_sum[AW-1:0];
                last <= pc_sum[AW];
                case (op_q)
                  OP_WRITE: begin
                    state   <= ST_WRITE;
                    m_cyc   <= 1'b1;
                    m_addr  <= addr_q;
                    m_wdata <= ram_rdata;
                  end
                  OP_WAIT: state <= ST_WAIT;
                  default: state <= ST_END;
                endcase
              end
              default: begin
                if (tg_y >= line_q) state <= last ? ST_END : ST_FETCH0;
              end
            endcase
          end
        end
        // A bus cycle is never abandoned; frame restarts wait for the ack.
        ST_WRITE: begin
          if (tg_eof) restart_pend <= 1'b1;
          if (m_ack) begin
            m_cyc        <= 1'b0;
            restart_pend <= 1'b0;
            if (!enable_nx) begin
              state <= ST_IDLE;
            end else if (tg_eof || restart_pend) begin
              state <= ST_FETCH0;
              pc    <= '0;
              last  <= 1'b0;
            end else begin
              state <= last ? ST_END : ST_FETCH0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vid_copper.sv
// Directed bench for vid_copper: a list-walking write model checked every
// cycle against the master port, plus hand-computed CSR and timing checks.
module tb_vid_copper;

  localparam int AW = 6;
  localparam logic [AW:0] CSR_ADDR = 7'h40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW:0]   cs_addr = '0;
  logic [31:0]   cs_wdata = '0;
  logic [31:0]   cs_rdata;
  logic          cs_we = 1'b0;
  logic          cs_cyc = 1'b0;
  logic          cs_ack;
  logic [13:0]   m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wmsk;
  logic          m_we;
  logic          m_cyc;
  logic          m_ack = 1'b0;
  logic [11:0]   tg_y = '0;
  logic          tg_eof = 1'b0;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  logic [31:0] lst [2**AW];
  logic [45:0] expw [$];
  int          exp_idx = 0;
  int          ack_cycles [$];
  int          ack_delay = 0;
  bit          ack_hold = 1'b0;
  int          cyc_cnt = 0;
  bit          cyc_prev = 1'b0;
  logic [11:0] y_first = '0;

  vid_copper #(.AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs_addr  (cs_addr),
    .cs_wdata (cs_wdata),
    .cs_rdata (cs_rdata),
    .cs_we    (cs_we),
    .cs_cyc   (cs_cyc),
    .cs_ack   (cs_ack),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wmsk   (m_wmsk),
    .m_we     (m_we),
    .m_cyc    (m_cyc),
    .m_ack    (m_ack),
    .tg_y     (tg_y),
    .tg_eof   (tg_eof),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] cmdWrite(input logic [13:0] a);
    return {2'b00, 16'h0000, a};
  endfunction

  function automatic logic [31:0] cmdWait(input logic [11:0] line);
    return {2'b01, 2'b00, line, 16'h0000};
  endfunction

  localparam logic [31:0] CMD_END = 32'h8000_0000;

  // Model: the writes one frame must produce, walking the list as the CPU wrote it.
  task automatic expectFrame(input int ymax);
    for (int i = 0; i < 2**(AW-1); i++) begin
      logic [31:0] w0;
      w0 = lst[2*i];
      if (w0[31:30] == 2'b00) expw.push_back({w0[13:0], lst[2*i+1]});
      else if (w0[31:30] == 2'b01) begin
        if (int'(w0[27:16]) > ymax) break;
      end else break;
    end
  endtask

  // Master-port monitor and ack responder.
  always @(negedge clk) begin
    if (rst) begin
      cyc_prev = 1'b0;
      cyc_cnt  = 0;
      m_ack    = 1'b0;
    end else begin
      checkOutput("m_we_eq_cyc", m_we, m_cyc);
      checkOutput("m_wmsk", m_wmsk, 4'b0000);
      if (cyc_prev && !m_ack) checkOutput("m_cyc_held", m_cyc, 1'b1);
      if (m_cyc) begin
        if (!cyc_prev) y_first = tg_y;
        if (exp_idx < expw.size()) checkOutput("m_addr_data", {m_addr, m_wdata}, expw[exp_idx]);
        else begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", m_addr, m_wdata);
        end
      end
      if (m_cyc && !ack_hold && cyc_cnt >= ack_delay) begin
        m_ack = 1'b1;
        exp_idx++;
        ack_cycles.push_back(cycle);
      end else begin
        m_ack = 1'b0;
      end
      cyc_cnt  = m_cyc ? cyc_cnt + 1 : 0;
      cyc_prev = m_cyc;
    end
  end

  task automatic waitAck(input int lat, output logic [31:0] d);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      tg_eof = 1'b0;
      n++;
    end while (!cs_ack && n < 8);
    checkOutput("cs_ack_latency", n, lat);
    d = cs_rdata;
    cs_cyc = 1'b0;
    cs_we  = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cs_ack_pulse", cs_ack, 1'b0);
    checkOutput("cs_rdata_idle", cs_rdata, 32'h0);
  endtask

  task automatic csWrite(input logic [AW:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    @(negedge clk);
    cs_addr = a; cs_wdata = d; cs_we = 1'b1; cs_cyc = 1'b1;
    waitAck(1, dummy);
  endtask

  task automatic csRead(input logic [AW:0] a, input bit eof, output logic [31:0] d);
    @(negedge clk);
    cs_addr = a; cs_we = 1'b0; cs_cyc = 1'b1; tg_eof = eof;
    waitAck(2, d);
  endtask

  task automatic loadCmd(input int i, input logic [31:0] w0, input logic [31:0] w1);
    lst[2*i]   = w0;
    lst[2*i+1] = w1;
    csWrite(7'(2*i), w0);
    csWrite(7'(2*i+1), w1);
  endtask

  // One-cycle end-of-frame pulse; returns just after the edge that samples it.
  task automatic applyStimulus();
    @(negedge clk);
    tg_eof = 1'b1;
    @(posedge clk);
    #1;
    tg_eof = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("busy_idle", busy, 1'b0);
  endtask

  task automatic waitCyc(input int budget);
    int n = 0;
    while (!m_cyc && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("m_cyc_rise", m_cyc, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int base;
    int ab;

    for (int i = 0; i < 2**AW; i++) lst[i] = CMD_END;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_m_cyc", m_cyc, 1'b0);
    checkOutput("reset_m_addr", m_addr, 14'h0);
    checkOutput("reset_cs_ack", cs_ack, 1'b0);

    csRead(CSR_ADDR, 1'b0, rd);
    checkOutput("csr_after_reset", rd, 32'h0000_0000);
    csWrite(CSR_ADDR, 32'h1);
    csRead(CSR_ADDR, 1'b0, rd);
    checkOutput("csr_enable", rd, 32'h0000_0001);
    checkOutput("busy_before_eof", busy, 1'b0);

    $display("[TB] single WRITE");
    loadCmd(0, cmdWrite(14'h1801), 32'h0000_0F0F);
    loadCmd(1, CMD_END, 32'h0);
    ack_delay = 3;
    base = expw.size();
    expectFrame(0);
    checkOutput("single_model_n", expw.size() - base, 1);
    checkOutput("single_model", expw[base], {14'h1801, 32'h0000_0F0F});
    applyStimulus();
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("latency_before", m_cyc, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("latency_at", m_cyc, 1'b1);
    checkOutput("single_addr", m_addr, 14'h1801);
    checkOutput("single_data", m_wdata, 32'h0000_0F0F);
    waitIdle(40);
    checkOutput("single_done", exp_idx, expw.size());

    $display("[TB] WAIT sweep");
    ack_delay = 0;
    loadCmd(0, cmdWait(12'd100), 32'h0);
    loadCmd(1, cmdWrite(14'h0000), 32'h0000_5001);
    loadCmd(2, CMD_END, 32'h0);
    for (int f = 0; f < 2; f++) begin
      base = expw.size();
      expectFrame(200);
      checkOutput("wait_model_n", expw.size() - base, 1);
      checkOutput("wait_model", expw[base], {14'h0000, 32'h0000_5001});
      @(negedge clk);
      tg_y = 12'd0;
      applyStimulus();
      for (int y = 1; y <= 200; y++) begin
        @(negedge clk);
        tg_y = 12'(y);
        if (y == 99) checkOutput("no_write_before_line", exp_idx, base);
      end
      waitIdle(20);
      checkOutput("wait_once", exp_idx, expw.size());
      checkOutput("wait_y_reached", y_first >= 12'd100, 1'b1);
    end

    $display("[TB] eof abort");
    @(negedge clk);
    tg_y = 12'd0;
    base = exp_idx;
    loadCmd(0, cmdWait(12'd4095), 32'h0);
    loadCmd(1, CMD_END, 32'h0);
    applyStimulus();
    repeat (6) @(posedge clk);
    csRead(CSR_ADDR, 1'b0, rd);
    checkOutput("abort_pc2", rd, 32'h0002_0003);
    repeat (6) @(posedge clk);
    csRead(CSR_ADDR, 1'b1, rd);
    checkOutput("abort_pc0", rd, 32'h0000_0003);
    repeat (6) @(posedge clk);
    csRead(CSR_ADDR, 1'b0, rd);
    checkOutput("abort_pc2_again", rd, 32'h0002_0003);
    checkOutput("abort_no_writes", exp_idx, base);
    csWrite(CSR_ADDR, 32'h0);
    waitIdle(10);
    csWrite(CSR_ADDR, 32'h1);

    $display("[TB] eof during WRITE");
    loadCmd(0, cmdWrite(14'h1234), 32'h0000_CAFE);
    loadCmd(1, CMD_END, 32'h0);
    ack_hold = 1'b1;
    base = exp_idx;
    expectFrame(0);
    expectFrame(0);
    applyStimulus();
    waitCyc(20);
    applyStimulus();
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("eof_write_held", m_cyc, 1'b1);
    ack_hold = 1'b0;
    waitIdle(60);
    checkOutput("eof_write_count", exp_idx - base, 2);
    checkOutput("eof_write_done", exp_idx, expw.size());

    $display("[TB] full list");
    for (int i = 0; i < 2**(AW-1); i++) loadCmd(i, cmdWrite(14'(32'h100 + i)), 32'(i * 3 + 7));
    base = exp_idx;
    ab = ack_cycles.size();
    expectFrame(0);
    checkOutput("full_model_n", expw.size() - base, 32);
    applyStimulus();
    waitIdle(400);
    checkOutput("full_count", exp_idx - base, 32);
    if (ack_cycles.size() >= ab + 32) begin
      checkOutput("b2b_gap_first", ack_cycles[ab+1] - ack_cycles[ab], 4);
      checkOutput("b2b_gap_last", ack_cycles[ab+31] - ack_cycles[ab+30], 4);
    end
    repeat (20) @(posedge clk);
    #1;
    checkOutput("full_no_rerun", exp_idx, expw.size());
    csRead(CSR_ADDR, 1'b0, rd);
    checkOutput("full_pc_wrap", rd, 32'h0000_0001);

    $display("[TB] reset mid-WRITE");
    ack_hold = 1'b1;
    expectFrame(0);
    applyStimulus();
    waitCyc(20);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_m_cyc", m_cyc, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ack_hold = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_stays_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
